// File: rtl/vga_capture_pkg.sv
// Shared definitions for the VGA capture block: lock FSM encoding,
// framebuffer geometry and the pixel-format / address helpers.
// Optional feature macro: VGA_CAPTURE_AVG_EN (4-pixel horizontal averaging).
package vga_capture_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;

  // Both position counters saturate here instead of wrapping.
  localparam logic [9:0] CNT_MAX = 10'd1023;

  // RGB565 -> RGB332 by keeping the top bits of each channel.
  function automatic logic [7:0] rgb332(input logic [4:0] r,
                                        input logic [5:0] g,
                                        input logic [4:0] b);
    return {r[4:2], g[5:3], b[4:3]};
  endfunction

  // row*160 + col, built as row*128 + row*32 + col (no multiplier).
  function automatic logic [14:0] fb_offset(input logic [7:0] row,
                                            input logic [7:0] col);
    return {row, 7'b0} + {2'b0, row, 5'b0} + {7'b0, col};
  endfunction

endpackage

// File: rtl/vga_sync_meter.sv
// Sync edge detection, pixel/line counters, line/frame length checks
// and the SEARCH -> ARM -> CAPTURE lock state machine.
// hc_pos/vc_pos are the coordinates of the pixel sampled on this pix_en.
module vga_sync_meter
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       vgaH,
  input  logic       vgaV,
  output logic [9:0] hc_pos,
  output logic [9:0] vc_pos,
  output logic       capture,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [10:0] H_LEN = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN = 11'(V_TOTAL);

  logic       h_q, v_q;
  logic       h_fall, v_fall;
  logic [9:0] hc, vc;
  logic       h_seen;
  logic       v_seen, v_seen_nxt;
  logic [1:0] line_cnt, line_cnt_nxt;
  logic       line_ok, frame_ok;
  logic       err_nxt;
  cap_state_e state, state_nxt;

  assign h_fall = pix_en & h_q & ~vgaH;
  assign v_fall = pix_en & v_q & ~vgaV;

  // The first edge after reset closes an unmeasured line/frame, so it never counts as good.
  assign line_ok  = h_seen && (({1'b0, hc} + 11'd1) == H_LEN);
  assign frame_ok = v_seen && (({1'b0, vc} + 11'd1) == V_LEN);

  assign capture = (state == CAPTURE);
  assign locked  = (state != SEARCH);

  // Position of the current sample; vsync clears vc ahead of the hsync increment.
  always_comb begin
    hc_pos = hc;
    vc_pos = vc;
    if (h_fall)                         hc_pos = '0;
    else if (pix_en && hc != CNT_MAX)   hc_pos = hc + 10'd1;
    if (v_fall)                         vc_pos = '0;
    else if (h_fall && vc != CNT_MAX)   vc_pos = vc + 10'd1;
  end

  // Sync history and position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q    <= 1'b1;
      v_q    <= 1'b1;
      hc     <= '0;
      vc     <= '0;
      h_seen <= 1'b0;
    end else begin
      if (pix_en) begin
        h_q <= vgaH;
        v_q <= vgaV;
      end
      if (h_fall) h_seen <= 1'b1;
      hc <= hc_pos;
      vc <= vc_pos;
    end
  end

  // Lock FSM state and measurement history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEARCH;
      line_cnt <= '0;
      v_seen   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_cnt_nxt;
      v_seen   <= v_seen_nxt;
      sync_err <= err_nxt;
    end
  end

  // Next state: lock needs two good lines in a row plus one good frame;
  // any bad measurement while locked drops back and forces a full re-measure.
  always_comb begin
    state_nxt    = state;
    line_cnt_nxt = line_cnt;
    v_seen_nxt   = v_seen;
    err_nxt      = 1'b0;
    if (h_fall) line_cnt_nxt = !line_ok ? 2'd0 : (line_cnt == 2'd2 ? 2'd2 : line_cnt + 2'd1);
    if (v_fall) v_seen_nxt = 1'b1;
    case (state)
      SEARCH: begin
        if (v_fall && frame_ok && line_cnt_nxt == 2'd2) state_nxt = ARM;
      end
      ARM, CAPTURE: begin
        if ((h_fall && !line_ok) || (v_fall && !frame_ok)) begin
          err_nxt      = 1'b1;
          state_nxt    = SEARCH;
          line_cnt_nxt = 2'd0;
          v_seen_nxt   = 1'b0;
        end else if (v_fall) begin
          state_nxt = CAPTURE;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

endmodule

// File: rtl/vga_capture.sv
// VGA capture top: decimates the 640x480 active area 4:1 in each axis
// into a 160x120 RGB332 framebuffer write stream.
// ACT_W/ACT_H size the active area; the defaults give the 160x120 buffer.
// Optional macro VGA_CAPTURE_AVG_EN averages the 4 pixels of each column
// group instead of taking the last one.
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int ACT_W   = 640,
  parameter int ACT_H   = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        vgaH,
  input  logic        vgaV,
  input  logic [4:0]  vgaR,
  input  logic [5:0]  vgaG,
  input  logic [4:0]  vgaB,
  output logic [14:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_we,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
);

  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + ACT_W);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + ACT_H);
  // Address of the last write of a frame (19199 with the default geometry).
  localparam logic [14:0] LAST_ADDR = 15'((ACT_H / 4 - 1) * FB_W + ACT_W / 4 - 1);

  logic [9:0]  hc_pos, vc_pos;
  logic        capture;
  logic        active, wr;
  logic [9:0]  ax, ay;
  logic [14:0] addr;
  logic [4:0]  r_sel;
  logic [5:0]  g_sel;
  logic [4:0]  b_sel;

  vga_sync_meter #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL)
  ) u_meter (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .vgaH     (vgaH),
    .vgaV     (vgaV),
    .hc_pos   (hc_pos),
    .vc_pos   (vc_pos),
    .capture  (capture),
    .locked   (locked),
    .sync_err (sync_err)
  );

  // Active-area decode and write selection for the current sample.
  always_comb begin
    active = ({1'b0, hc_pos} >= H_LO) && ({1'b0, hc_pos} < H_HI) &&
             ({1'b0, vc_pos} >= V_LO) && ({1'b0, vc_pos} < V_HI);
    ax     = hc_pos - H_LO[9:0];
    ay     = vc_pos - V_LO[9:0];
    wr     = pix_en && capture && active && (ax[1:0] == 2'd3) && (ay[1:0] == 2'd0);
    addr   = fb_offset(ay[9:2], ax[9:2]);
  end

`ifdef VGA_CAPTURE_AVG_EN
  logic [6:0] r_acc, r_sum;
  logic [7:0] g_acc, g_sum;
  logic [6:0] b_acc, b_sum;

  // Running sum over the column group; ax[1:0]==0 restarts from the current pixel.
  always_comb begin
    r_sum = {2'b0, vgaR};
    g_sum = {2'b0, vgaG};
    b_sum = {2'b0, vgaB};
    if (ax[1:0] != 2'd0) begin
      r_sum = r_acc + {2'b0, vgaR};
      g_sum = g_acc + {2'b0, vgaG};
      b_sum = b_acc + {2'b0, vgaB};
    end
    r_sel = r_sum[6:2];
    g_sel = g_sum[7:2];
    b_sel = b_sum[6:2];
  end

  // Accumulator registers, advanced on every active sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      g_acc <= '0;
      b_acc <= '0;
    end else if (pix_en && active) begin
      r_acc <= r_sum;
      g_acc <= g_sum;
      b_acc <= b_sum;
    end
  end
`else
  assign r_sel = vgaR;
  assign g_sel = vgaG;
  assign b_sel = vgaB;
`endif

  // Registered write port; frame_done trails the final write by one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      frame_done <= 1'b0;
    end else begin
      fb_we      <= wr;
      frame_done <= fb_we && (fb_addr == LAST_ADDR);
      if (wr) begin
        fb_addr <= addr;
        fb_data <= rgb332(r_sel, g_sel, b_sel);
      end
    end
  end

endmodule
